pwm_capture: RTL and testbench

Multi-lane PWM pulse-width decoder: the receive end of the 8-stage PWM generator. On each `hsync` frame strobe it measures, per lane, the number of counter-clock cycles each PWM output is high, then returns the recovered `DWIDTH`-bit values one lane at a time over a valid/ready stream. It sits on the counter-clock domain and is used for loopback checking of the PWM output stage and as a PWM-input front end.

---
 rtl/pwm_capture.sv | 150 +++++++++++++++
 tb/tb_pwm_capture.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// Multi-lane PWM pulse-width decoder: counts high cycles per lane over a 2^DWIDTH window, then streams results.
// Optional macro PWM_CAPTURE_GLITCH_CHECK_EN adds per-lane fall-then-rise detection folded into out_flag.
module pwm_capture #(
  parameter int STAGE  = 8,
  parameter int DWIDTH = 8,
  localparam int LW    = (STAGE > 1) ? $clog2(STAGE) : 1
) (
  input  logic              clkforcounter,
  input  logic              rst,
  input  logic              hsync,
  input  logic [0:STAGE-1]  in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [LW-1:0]     out_lane,
  output logic              out_flag,
  output logic              busy,
  output logic              drop,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, MEASURE, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] win_q, win_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic              valid_q, valid_d;
  logic              drop_q, drop_d;
  logic              done_q, done_d;
  logic [DWIDTH-1:0] cnt_q [STAGE];
  logic [DWIDTH-1:0] cnt_d [STAGE];
  logic [STAGE-1:0]  sat_q, sat_d;
  logic [STAGE-1:0]  glitch_q;

`ifdef PWM_CAPTURE_GLITCH_CHECK_EN
  logic [STAGE-1:0]  prev_q, prev_d;
  logic [STAGE-1:0]  fell_q, fell_d;
  logic [STAGE-1:0]  glitch_d;
`else
  assign glitch_q = '0;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    lane_d  = lane_q;
    valid_d = valid_q;
    drop_d  = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
`ifdef PWM_CAPTURE_GLITCH_CHECK_EN
    prev_d   = prev_q;
    fell_d   = fell_q;
    glitch_d = glitch_q;
`endif
    case (state_q)
      IDLE: begin
        if (hsync) begin
          state_d = MEASURE;
          win_d   = '0;
          lane_d  = '0;
          valid_d = 1'b0;
          for (int i = 0; i < STAGE; i++) cnt_d[i] = '0;
          sat_d   = '0;
`ifdef PWM_CAPTURE_GLITCH_CHECK_EN
          prev_d   = '0;
          fell_d   = '0;
          glitch_d = '0;
`endif
        end
      end
      MEASURE: begin
        drop_d = hsync;
        win_d  = win_q + DWIDTH'(1);
        for (int i = 0; i < STAGE; i++) begin
          // A full counter holds its value and records saturation instead of wrapping.
          if (in[i]) begin
            if (cnt_q[i] == '1) sat_d[i] = 1'b1;
            else                cnt_d[i] = cnt_q[i] + DWIDTH'(1);
          end
`ifdef PWM_CAPTURE_GLITCH_CHECK_EN
          if (prev_q[i] && !in[i]) fell_d[i]   = 1'b1;
          if (fell_q[i] && in[i])  glitch_d[i] = 1'b1;
          prev_d[i] = in[i];
`endif
        end
        if (win_q == '1) state_d = DRAIN;
      end
      DRAIN: begin
        drop_d = hsync;
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (out_ready) begin
          if (lane_q == LW'(STAGE - 1)) begin
            state_d = IDLE;
            valid_d = 1'b0;
            lane_d  = '0;
            done_d  = 1'b1;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkforcounter) begin
    if (!rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < STAGE; i++) cnt_q[i] <= '0;
      sat_q   <= '0;
`ifdef PWM_CAPTURE_GLITCH_CHECK_EN
      prev_q   <= '0;
      fell_q   <= '0;
      glitch_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
`ifdef PWM_CAPTURE_GLITCH_CHECK_EN
      prev_q   <= prev_d;
      fell_q   <= fell_d;
      glitch_q <= glitch_d;
`endif
    end
  end

  // Data and flag are gated so they read zero whenever no beat is offered.
  assign out_valid  = valid_q;
  assign out_lane   = lane_q;
  assign out_data   = valid_q ? cnt_q[lane_q] : '0;
  assign out_flag   = valid_q & (sat_q[lane_q] | glitch_q[lane_q]);
  assign busy       = (state_q != IDLE);
  assign drop       = drop_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: a window-level reference model plus directed literal checks.
// Honours PWM_CAPTURE_GLITCH_CHECK_EN to pick the expected out_flag rule.
module tb_pwm_capture;
  localparam int STAGE  = 8;
  localparam int DWIDTH = 8;
  localparam int WIN    = 1 << DWIDTH;

`ifdef PWM_CAPTURE_GLITCH_CHECK_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              hsync;
  logic              outReady;
  logic [0:STAGE-1]  inBus;
  logic              outValid;
  logic [DWIDTH-1:0] outData;
  logic [2:0]        outLane;
  logic              outFlag;
  logic              busy;
  logic              drop;
  logic              frameDone;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  bit wave [STAGE][WIN];
  int widths [STAGE] = '{0, 1, 17, 64, 128, 200, 254, 255};

  bit mInFrame;
  int mT;
  int mBeats;
  bit expDrop;
  bit expDone;
  bit mSamples [STAGE][WIN];
  int expData [STAGE];
  bit expFlag [STAGE];

  int capData [STAGE];
  bit capFlag [STAGE];
  int capCount;
  int dropCount;
  int doneEdge;

  pwm_capture #(.STAGE(STAGE), .DWIDTH(DWIDTH)) dut (
    .clkforcounter(clk),
    .rst(rst),
    .hsync(hsync),
    .in(inBus),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_data(outData),
    .out_lane(outLane),
    .out_flag(outFlag),
    .busy(busy),
    .drop(drop),
    .frame_done(frameDone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Expected results come from counting ones in the recorded window and scanning for a 1-0-1 shape.
  task automatic computeExpected();
    for (int i = 0; i < STAGE; i++) begin
      int sum = 0;
      bit seen = 0;
      bit fell = 0;
      bit gl = 0;
      for (int k = 0; k < WIN; k++) begin
        if (mSamples[i][k]) begin
          sum++;
          if (fell) gl = 1;
          seen = 1;
        end else if (seen) begin
          fell = 1;
        end
      end
      expData[i] = (sum > WIN - 1) ? WIN - 1 : sum;
      expFlag[i] = (sum > WIN - 1) || (GLITCH && gl);
    end
  endtask

  task automatic modelStep(input logic h, input logic [0:STAGE-1] lanes, input logic rdy, input logic r);
    expDrop = 0;
    expDone = 0;
    if (!r) begin
      mInFrame = 0;
      mT = 0;
      mBeats = 0;
    end else if (!mInFrame) begin
      if (h) begin
        mInFrame = 1;
        mT = 0;
        mBeats = 0;
      end
    end else begin
      mT++;
      expDrop = h;
      if (mT <= WIN) for (int i = 0; i < STAGE; i++) mSamples[i][mT-1] = lanes[i];
      if (mT == WIN) computeExpected();
      if (mT >= WIN + 2 && rdy) begin
        mBeats++;
        if (mBeats == STAGE) begin
          mInFrame = 0;
          expDone = 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic h, input logic [0:STAGE-1] lanes, input logic rdy, input logic r);
    hsync    = h;
    inBus    = lanes;
    outReady = rdy;
    rst      = r;
    @(posedge clk);
    modelStep(h, lanes, rdy, r);
    #2;
  endtask

  function automatic logic pickReady(input int mode, input int step);
    case (mode)
      0:       return 1'b1;
      1:       return (step % 4 == 0) || (step % 4 == 3);
      default: return ($urandom_range(3) != 0);
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        bit expValid;
        expValid = mInFrame && (mT >= WIN + 1);
        checkOutput("busy", 32'(busy), 32'(mInFrame));
        checkOutput("out_valid", 32'(outValid), 32'(expValid));
        checkOutput("drop", 32'(drop), 32'(expDrop));
        checkOutput("frame_done", 32'(frameDone), 32'(expDone));
        if (mInFrame && mT >= WIN) checkOutput("out_lane", 32'(outLane), 32'(mBeats));
        if (expValid) begin
          checkOutput($sformatf("out_data_lane%0d", mBeats), 32'(outData), 32'(expData[mBeats]));
          checkOutput($sformatf("out_flag_lane%0d", mBeats), 32'(outFlag), 32'(expFlag[mBeats]));
          if (outValid === 1'b1 && outReady) begin
            capData[outLane] = int'(outData);
            capFlag[outLane] = outFlag;
            capCount++;
          end
        end
        if (drop === 1'b1) dropCount++;
      end
    end
  end

  task automatic runFrame(input int readyMode, input int dropAt, input int drainDropAt,
                          input int rstAt, input bit randHs);
    logic [0:STAGE-1] col;
    logic hs;
    int step;
    int edgeNo;
    capCount  = 0;
    dropCount = 0;
    doneEdge  = -1;
    for (int i = 0; i < STAGE; i++) begin
      capData[i] = -1;
      capFlag[i] = 0;
    end
    applyStimulus(1'b1, '0, 1'b1, 1'b1);
    for (int t = 1; t <= WIN; t++) begin
      for (int i = 0; i < STAGE; i++) col[i] = wave[i][t-1];
      if (t == rstAt) begin
        applyStimulus(1'b0, col, 1'b1, 1'b0);
        return;
      end
      hs = (t == dropAt) || (randHs && $urandom_range(63) == 0);
      applyStimulus(hs, col, pickReady(readyMode, 0), 1'b1);
    end
    edgeNo = WIN;
    step   = 0;
    while (mInFrame && step < 64) begin
      hs = (step == drainDropAt) || (randHs && $urandom_range(15) == 0);
      applyStimulus(hs, 8'($urandom), pickReady(readyMode, step), 1'b1);
      step++;
      edgeNo++;
      if (frameDone === 1'b1 && doneEdge < 0) doneEdge = edgeNo;
    end
    if (mInFrame) begin
      testsFailed++;
      $display("[TB] FAIL drain_budget: frame still open after %0d drain cycles, required at most 64", step);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic loadWidths();
    for (int i = 0; i < STAGE; i++)
      for (int k = 0; k < WIN; k++) wave[i][k] = (k < widths[i]);
  endtask

  task automatic checkWidths(input string tag);
    for (int i = 0; i < STAGE; i++) begin
      checkOutput($sformatf("%s_lane%0d_data", tag, i), 32'(capData[i]), 32'(widths[i]));
      checkOutput($sformatf("%s_lane%0d_flag", tag, i), 32'(capFlag[i]), 32'(0));
    end
  endtask

  task automatic genRandomWave();
    for (int i = 0; i < STAGE; i++) begin
      int kind = $urandom_range(3);
      int s = $urandom_range(WIN - 1);
      int w = $urandom_range(WIN - 1);
      bit lvl = 0;
      for (int k = 0; k < WIN; k++) begin
        case (kind)
          0: wave[i][k] = (k < w);
          1: wave[i][k] = (k >= s) && (k < s + w);
          2: begin
            if ($urandom_range(7) == 0) lvl = !lvl;
            wave[i][k] = lvl;
          end
          default: wave[i][k] = 1'b1;
        endcase
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    hsync = 0; inBus = '0; outReady = 0; rst = 0;
    mInFrame = 0; mT = 0; mBeats = 0; expDrop = 0; expDone = 0;
    capCount = 0; dropCount = 0; doneEdge = -1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkEn = 1'b1;
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_valid", 32'(outValid), 32'(0));
    checkOutput("reset_lane", 32'(outLane), 32'(0));
    checkOutput("reset_data", 32'(outData), 32'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Widths frame with ready held high: exact values and frame_done 265 edges after T0.
    loadWidths();
    runFrame(0, 0, -1, 0, 1'b0);
    checkWidths("widths");
    checkOutput("widths_beats", 32'(capCount), 32'(8));
    checkOutput("widths_done_edge", 32'(doneEdge), 32'(WIN + 1 + STAGE));

    loadWidths();
    for (int k = 0; k < WIN; k++) wave[3][k] = 1'b1;
    runFrame(0, 0, -1, 0, 1'b0);
    checkOutput("sat_lane3_data", 32'(capData[3]), 32'(255));
    checkOutput("sat_lane3_flag", 32'(capFlag[3]), 32'(1));
    checkOutput("sat_lane2_data", 32'(capData[2]), 32'(17));
    checkOutput("sat_lane4_flag", 32'(capFlag[4]), 32'(0));

    loadWidths();
    runFrame(1, 0, -1, 0, 1'b0);
    checkWidths("stall");
    checkOutput("stall_beats", 32'(capCount), 32'(8));

    loadWidths();
    runFrame(0, 50, 3, 0, 1'b0);
    checkWidths("dropped");
    checkOutput("dropped_pulses", 32'(dropCount), 32'(2));

    loadWidths();
    runFrame(0, 0, -1, 100, 1'b0);
    checkOutput("midreset_busy", 32'(busy), 32'(0));
    checkOutput("midreset_valid", 32'(outValid), 32'(0));
    checkOutput("midreset_lane", 32'(outLane), 32'(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    runFrame(0, 0, -1, 0, 1'b0);
    checkWidths("after_reset");

    for (int i = 0; i < STAGE; i++)
      for (int k = 0; k < WIN; k++) wave[i][k] = 1'b0;
    for (int k = 0; k < 10; k++) wave[5][k] = 1'b1;
    for (int k = 19; k < 24; k++) wave[5][k] = 1'b1;
    runFrame(0, 0, -1, 0, 1'b0);
    checkOutput("glitch_lane5_data", 32'(capData[5]), 32'(15));
    checkOutput("glitch_lane5_flag", 32'(capFlag[5]), 32'(GLITCH));

    for (int n = 0; n < 8; n++) begin
      genRandomWave();
      runFrame(2, 0, -1, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
